// File: rtl/alu_slice_pkg.sv
// alu_slice_pkg
// Shared types for the serial ALU slice sequencer.
//   op_e        : slice operation encoding carried on {sl_op1, sl_op0}
//   seq_state_e : sequencer FSM states
//   is_term()   : any terminal-state pulse from the slice
package alu_slice_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        DRIVE = 2'b10,
        RESP  = 2'b11
    } seq_state_e;

    function automatic logic is_term(input logic error, input logic zero,
                                     input logic y0, input logic y1);
        return error | zero | y0 | y1;
    endfunction

endpackage

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
// Initiator for a shared 1-bit ALU slice FSM. Takes a WIDTH-bit request,
// walks it through the slice LSB first with carry chained bit to bit, and
// returns result/cout/error/timeout on a valid/ready response port.
//
// Ports
//   clk, reset                 clock; async active-high reset (also resets the slice)
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_a, req_b [WIDTH]       operands
//   req_op [2]                 00 AND, 01 OR, 10 ADD, 11 illegal
//   req_binv, req_cin          invert b, carry into bit 0
//   rsp_valid/rsp_ready        response handshake, response held until accepted
//   rsp_result [WIDTH]         Y0 of each bit
//   rsp_cout                   Y1 of the last bit
//   rsp_error, rsp_timeout     slice error / no terminal pulse within TIMEOUT
//   sl_a..sl_cin               registered slice inputs
//   sl_error,sl_zero,sl_y0,sl_y1  slice terminal-state pulses
//   sl_clr                     one-cycle slice clear after a timeout
//
// state | meaning
// IDLE  | ready for a request, slice inputs parked at 0
// SYNC  | waiting for the free-running slice to finish its idle walk
// DRIVE | slice working on bit r_bit with inputs held stable
// RESP  | response presented until the host accepts it
import alu_slice_pkg::*;

module alu_slice_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic             req_binv,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_error,
    output logic             rsp_timeout,
    output logic             sl_a,
    output logic             sl_b,
    output logic             sl_op0,
    output logic             sl_op1,
    output logic             sl_binv,
    output logic             sl_cin,
    input  logic             sl_error,
    input  logic             sl_zero,
    input  logic             sl_y0,
    input  logic             sl_y1,
    output logic             sl_clr
);

    localparam int BIT_W  = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

    seq_state_e        r_state, w_state;
    logic [WIDTH-1:0]  r_a, w_a;
    logic [WIDTH-1:0]  r_b, w_b;
    op_e               r_op, w_op;
    logic              r_binv, w_binv;
    logic              r_carry, w_carry;
    logic [BIT_W-1:0]  r_bit, w_bit;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt;
    logic [WIDTH-1:0]  r_result, w_result;
    logic              r_cout, w_cout;
    logic              r_error, w_error;
    logic              r_timeout, w_timeout;
    logic              r_sl_a, w_sl_a;
    logic              r_sl_b, w_sl_b;
    logic [1:0]        r_sl_op, w_sl_op;
    logic              r_sl_binv, w_sl_binv;
    logic              r_sl_cin, w_sl_cin;
    logic              r_sl_clr, w_sl_clr;

    logic              w_term;
    logic              w_expire;
    logic [BIT_W-1:0]  w_nbit;

    assign w_term   = is_term(sl_error, sl_zero, sl_y0, sl_y1);
    assign w_expire = (r_wcnt == WCNT_MAX);
    assign w_nbit   = r_bit + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_AND;
            r_binv    <= 1'b0;
            r_carry   <= 1'b0;
            r_bit     <= '0;
            r_wcnt    <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_sl_a    <= 1'b0;
            r_sl_b    <= 1'b0;
            r_sl_op   <= 2'b00;
            r_sl_binv <= 1'b0;
            r_sl_cin  <= 1'b0;
            r_sl_clr  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_a       <= w_a;
            r_b       <= w_b;
            r_op      <= w_op;
            r_binv    <= w_binv;
            r_carry   <= w_carry;
            r_bit     <= w_bit;
            r_wcnt    <= w_wcnt;
            r_result  <= w_result;
            r_cout    <= w_cout;
            r_error   <= w_error;
            r_timeout <= w_timeout;
            r_sl_a    <= w_sl_a;
            r_sl_b    <= w_sl_b;
            r_sl_op   <= w_sl_op;
            r_sl_binv <= w_sl_binv;
            r_sl_cin  <= w_sl_cin;
            r_sl_clr  <= w_sl_clr;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_a       = r_a;
        w_b       = r_b;
        w_op      = r_op;
        w_binv    = r_binv;
        w_carry   = r_carry;
        w_bit     = r_bit;
        w_wcnt    = r_wcnt;
        w_result  = r_result;
        w_cout    = r_cout;
        w_error   = r_error;
        w_timeout = r_timeout;
        w_sl_a    = r_sl_a;
        w_sl_b    = r_sl_b;
        w_sl_op   = r_sl_op;
        w_sl_binv = r_sl_binv;
        w_sl_cin  = r_sl_cin;
        w_sl_clr  = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_a       = req_a;
                    w_b       = req_b;
                    w_op      = op_e'(req_op);
                    w_binv    = req_binv;
                    w_carry   = req_cin;
                    w_bit     = '0;
                    w_wcnt    = '0;
                    // Clearing here means bits never reached read back as 0.
                    w_result  = '0;
                    w_cout    = 1'b0;
                    w_error   = 1'b0;
                    w_timeout = 1'b0;
                    w_state   = SYNC;
                end
            end

            SYNC: begin
                if (w_term) begin
                    // Load on the term edge so the slice samples bit 0 in its S0 cycle.
                    w_sl_a    = r_a[0];
                    w_sl_b    = r_b[0];
                    w_sl_op   = r_op;
                    w_sl_binv = r_binv;
                    w_sl_cin  = r_carry;
                    w_wcnt    = '0;
                    w_state   = DRIVE;
                end else if (w_expire) begin
                    w_timeout = 1'b1;
                    w_sl_clr  = 1'b1;
                    w_state   = RESP;
                end else begin
                    w_wcnt = r_wcnt + 1'b1;
                end
            end

            DRIVE: begin
                if (sl_error) begin
                    w_error   = 1'b1;
                    w_sl_a    = 1'b0;
                    w_sl_b    = 1'b0;
                    w_sl_op   = 2'b00;
                    w_sl_binv = 1'b0;
                    w_sl_cin  = 1'b0;
                    w_state   = RESP;
                end else if (w_term) begin
                    w_result[r_bit] = sl_y0;
                    w_carry         = sl_y1;
                    if (r_bit == LAST_BIT) begin
                        w_cout    = sl_y1;
                        w_sl_a    = 1'b0;
                        w_sl_b    = 1'b0;
                        w_sl_op   = 2'b00;
                        w_sl_binv = 1'b0;
                        w_sl_cin  = 1'b0;
                        w_state   = RESP;
                    end else begin
                        // Next bit goes out on the same edge; carry comes straight from Y1.
                        w_bit     = w_nbit;
                        w_sl_a    = r_a[w_nbit];
                        w_sl_b    = r_b[w_nbit];
                        w_sl_cin  = sl_y1;
                        w_wcnt    = '0;
                    end
                end else if (w_expire) begin
                    w_timeout = 1'b1;
                    w_sl_clr  = 1'b1;
                    w_sl_a    = 1'b0;
                    w_sl_b    = 1'b0;
                    w_sl_op   = 2'b00;
                    w_sl_binv = 1'b0;
                    w_sl_cin  = 1'b0;
                    w_state   = RESP;
                end else begin
                    w_wcnt = r_wcnt + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_result  = '0;
                    w_cout    = 1'b0;
                    w_error   = 1'b0;
                    w_timeout = 1'b0;
                    w_state   = IDLE;
                end
            end

            default: w_state = IDLE;
        endcase
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_result  = r_result;
    assign rsp_cout    = r_cout;
    assign rsp_error   = r_error;
    assign rsp_timeout = r_timeout;
    assign sl_a        = r_sl_a;
    assign sl_b        = r_sl_b;
    assign sl_op0      = r_sl_op[0];
    assign sl_op1      = r_sl_op[1];
    assign sl_binv     = r_sl_binv;
    assign sl_cin      = r_sl_cin;
    assign sl_clr      = r_sl_clr;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer
// Drives alu_slice_sequencer against a behavioural slice FSM partner.
// Slice model: S0 samples inputs, then walks to a terminal pulse after
// 4 (error) or 5 + a + b' + cin cycles; all-zero inputs give a 5-cycle idle loop.
module tb_alu_slice_sequencer;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic       binv;
        logic       cin;
        logic [3:0] res;
        logic       cout;
        logic       err;
        logic       to;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [WIDTH-1:0] req_a, req_b;
    logic [1:0]       req_op;
    logic             req_binv, req_cin;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout, rsp_error, rsp_timeout;
    logic             sl_a, sl_b, sl_op0, sl_op1, sl_binv, sl_cin;
    logic             sl_error, sl_zero, sl_y0, sl_y1, sl_clr;

    int n_vec  = 0;
    int n_err  = 0;
    int n_rsp  = 0;
    int cyc    = 0;
    vec_t exp_q[$];
    vec_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_slice_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_binv(req_binv), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .sl_a(sl_a), .sl_b(sl_b), .sl_op0(sl_op0), .sl_op1(sl_op1),
        .sl_binv(sl_binv), .sl_cin(sl_cin),
        .sl_error(sl_error), .sl_zero(sl_zero), .sl_y0(sl_y0), .sl_y1(sl_y1),
        .sl_clr(sl_clr)
    );

    // ---------------- slice partner ----------------
    logic       stuck = 1'b0;
    logic       s_rst;
    int         s_cnt, s_len, c_len;
    logic [1:0] s_val, c_val;
    logic       s_err, c_err, c_be, s_term;

    assign s_rst = reset | sl_clr;

    always_comb begin
        c_be  = sl_b ^ sl_binv;
        c_val = 2'b00;
        c_err = 1'b0;
        case ({sl_op1, sl_op0})
            2'b00: c_val = {1'b0, sl_a & c_be};
            2'b01: c_val = {1'b0, sl_a | c_be};
            2'b10: c_val = {(sl_a & c_be) | (sl_cin & (sl_a ^ c_be)), sl_a ^ c_be ^ sl_cin};
            default: c_err = 1'b1;
        endcase
        c_len = c_err ? 4 : 5 + int'(sl_a) + int'(c_be) + int'(sl_cin);
    end

    always @(posedge clk or posedge s_rst) begin
        if (s_rst) begin
            s_cnt <= 0; s_len <= 5; s_val <= 2'b00; s_err <= 1'b0;
        end else if (s_cnt == 0) begin
            s_cnt <= 1; s_len <= c_len; s_val <= c_val; s_err <= c_err;
        end else if (s_cnt >= s_len - 1) begin
            s_cnt <= 0;
        end else begin
            s_cnt <= s_cnt + 1;
        end
    end

    assign s_term   = (s_cnt != 0) && (s_cnt == s_len - 1) && !stuck;
    assign sl_error = s_term & s_err;
    assign sl_y0    = s_term & !s_err & s_val[0];
    assign sl_y1    = s_term & !s_err & s_val[1];
    assign sl_zero  = s_term & !s_err & (s_val == 2'b00);

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got response res=%0h, expected none", rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_result",  32'(rsp_result),  32'(mon_e.res));
                chk("rsp_cout",    32'(rsp_cout),    32'(mon_e.cout));
                chk("rsp_error",   32'(rsp_error),   32'(mon_e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
            end
            n_rsp++;
        end
    end

    task automatic send(input vec_t v, input bit push);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 200) begin @(negedge clk); k++; end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_a = v.a; req_b = v.b; req_op = v.op; req_binv = v.binv; req_cin = v.cin;
        req_valid = 1'b1;
        if (push) exp_q.push_back(v);
        n_vec++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble operands: must not leak into the running operation.
        req_a = 4'($urandom); req_b = 4'($urandom); req_op = 2'($urandom);
        req_binv = 1'($urandom); req_cin = 1'($urandom);
    endtask

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (n_rsp < target && k < 400) begin @(negedge clk); k++; end
        chk("rsp_count", 32'(n_rsp), 32'(target));
        @(posedge clk); #1;
    endtask

    vec_t tbl[10];
    vec_t v;
    logic [4:0] s;
    int t0, clr_hi;

    initial begin
        tbl[0] = '{4'b0011, 4'b0101, 2'b10, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b0101, 4'b0011, 2'b10, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'b1111, 4'b0001, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'b1100, 4'b1010, 2'b00, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4'b0011, 4'b0101, 2'b11, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{4'b0110, 4'b0111, 2'b10, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'b1001, 4'b0100, 2'b01, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{4'b0001, 4'b1110, 2'b01, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{4'b1010, 4'b0101, 2'b10, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{4'b1111, 4'b0101, 2'b00, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        req_binv = 1'b0; req_cin = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_result, rsp_cout, rsp_error, rsp_timeout}), 32'd0);
        chk("rst_sl_bus", 32'({sl_a, sl_b, sl_op0, sl_op1, sl_binv, sl_cin, sl_clr}), 32'd0);
        @(negedge clk); reset = 1'b0;

        foreach (tbl[i]) begin
            send(tbl[i], 1'b1);
            wait_rsp(n_rsp + 1);
        end

        for (int i = 0; i < 8; i++) begin
            v.a = 4'($urandom); v.b = 4'($urandom); v.op = 2'b10;
            v.binv = 1'($urandom); v.cin = 1'($urandom);
            s = {1'b0, v.a} + {1'b0, (v.binv ? ~v.b : v.b)} + {4'b0, v.cin};
            v.res = s[3:0]; v.cout = s[4]; v.err = 1'b0; v.to = 1'b0;
            send(v, 1'b1);
            wait_rsp(n_rsp + 1);
        end

        // Timeout with the host stalling the response.
        stuck = 1'b1;
        rsp_ready = 1'b0;
        v = '{4'b0101, 4'b0011, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        send(v, 1'b1);
        t0 = cyc;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
        chk("to_seen", 32'(rsp_valid), 32'd1);
        chk("to_latency", 32'(cyc - t0), 32'(TIMEOUT));
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_sl_clr", 32'(sl_clr), 32'd1);
        clr_hi = int'(sl_clr);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clr_hi += int'(sl_clr);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", 32'({rsp_result, rsp_timeout}), 32'b0_0001);
        end
        chk("sl_clr_width", 32'(clr_hi), 32'd1);
        stuck = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp(n_rsp + 1);

        send(tbl[0], 1'b1);
        wait_rsp(n_rsp + 1);

        // Reset mid-operation: no response may appear afterwards.
        v = '{4'b1111, 4'b1111, 2'b10, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0};
        send(v, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("midop_sl_a", 32'(sl_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("midop_rst_ready", 32'(req_ready), 32'd1);
        chk("midop_rst_bus", 32'({rsp_valid, rsp_result, rsp_cout, sl_a, sl_b, sl_cin}), 32'd0);
        @(negedge clk); reset = 1'b0;
        t0 = n_rsp;
        repeat (60) @(negedge clk);
        chk("midop_no_rsp", 32'(n_rsp), 32'(t0));

        send(tbl[1], 1'b1);
        wait_rsp(n_rsp + 1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
